// File: rtl/dc_blocker_mc.sv
// dc_blocker_mc: multichannel moving-average DC blocker sharing one history RAM.
// Optional output saturation: define DC_BLOCKER_MC_SAT_EN (low-WIDTH-bit wrap otherwise).
module dc_blocker_mc #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      audio_en,
  input  logic [CHANNELS*WIDTH-1:0] sample,
  output logic [CHANNELS*WIDTH-1:0] filtered,
  output logic                      valid,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      overrun_clr
);
  localparam int LD    = $clog2(DEPTH);
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW    = CW + LD;
  localparam int SW    = WIDTH + LD;
  localparam int WORDS = CHANNELS * DEPTH;
  localparam logic [AW-1:0] CLR_LAST = AW'(WORDS - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_UPD, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [AW-1:0]          r_clr_cnt;
  logic [CW-1:0]          r_ch;
  logic [LD-1:0]          r_idx;
  logic                   r_valid;
  logic                   r_overrun;
  logic signed [WIDTH-1:0] r_in   [CHANNELS];
  logic signed [SW-1:0]    r_sum  [CHANNELS];
  logic signed [WIDTH-1:0] r_out  [CHANNELS];
  logic signed [WIDTH-1:0] r_filt [CHANNELS];
  logic [WIDTH-1:0]        r_mem  [WORDS];
  logic [WIDTH-1:0]        r_rd_data;

  logic                    w_capture;
  logic                    w_rd;
  logic                    w_upd;
  logic                    w_done;
  logic                    w_clr;
  logic                    w_drop;
  logic                    w_we;
  logic [AW-1:0]           w_waddr;
  logic [AW-1:0]           w_raddr;
  logic [WIDTH-1:0]        w_wdata;
  logic signed [WIDTH-1:0] w_sample [CHANNELS];
  logic signed [WIDTH-1:0] w_new;
  logic signed [SW-1:0]    w_new_ext;
  logic signed [SW-1:0]    w_old_ext;
  logic signed [SW-1:0]    w_sum_next;
  logic signed [WIDTH-1:0] w_dc;
  logic signed [WIDTH-1:0] w_out;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign w_sample[gi]                  = sample[gi*WIDTH +: WIDTH];
      assign filtered[gi*WIDTH +: WIDTH]   = r_filt[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_rd         = 1'b0;
    w_upd        = 1'b0;
    w_done       = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr = 1'b1;
        if (r_clr_cnt == CLR_LAST) w_state_next = S_IDLE;
      end
      S_IDLE: begin
        if (audio_en) begin
          w_capture    = 1'b1;
          w_state_next = S_RD;
        end
      end
      S_RD: begin
        w_rd         = 1'b1;
        w_state_next = S_UPD;
      end
      S_UPD: begin
        w_upd        = 1'b1;
        w_state_next = (r_ch == CH_LAST) ? S_DONE : S_RD;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_CLEAR;
    endcase
  end

  // Strobes are only accepted in IDLE; CLEAR silently ignores them.
  assign w_drop = audio_en && (r_state != S_IDLE) && (r_state != S_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_cnt <= '0;
      r_ch      <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_clr) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_capture) begin
        r_ch <= '0;
      end else if (w_upd && (r_ch != CH_LAST)) begin
        r_ch <= r_ch + 1'b1;
      end
      if (w_done) r_idx <= r_idx + 1'b1;
      r_valid <= w_done;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign w_we    = (w_clr || w_upd) && !reset;
  assign w_raddr = {r_ch, r_idx};
  assign w_waddr = w_clr ? r_clr_cnt : {r_ch, r_idx};
  assign w_wdata = w_clr ? '0 : w_new;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_rd) r_rd_data <= r_mem[w_raddr];
  end

  assign w_new      = r_in[r_ch];
  assign w_new_ext  = {{LD{w_new[WIDTH-1]}}, w_new};
  assign w_old_ext  = {{LD{r_rd_data[WIDTH-1]}}, r_rd_data};
  assign w_sum_next = r_sum[r_ch] - w_old_ext + w_new_ext;
  // Upper WIDTH bits of the window sum are the floored arithmetic shift by log2(DEPTH).
  assign w_dc       = w_sum_next[SW-1:LD];

`ifdef DC_BLOCKER_MC_SAT_EN
  logic signed [WIDTH:0] w_diff;
  assign w_diff = {w_new[WIDTH-1], w_new} - {w_dc[WIDTH-1], w_dc};
  always_comb begin
    w_out = w_diff[WIDTH-1:0];
    if (w_diff[WIDTH] != w_diff[WIDTH-1]) begin
      w_out = w_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_out = w_new - w_dc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_in[i]   <= '0;
        r_sum[i]  <= '0;
        r_out[i]  <= '0;
        r_filt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_capture) r_in[i] <= w_sample[i];
        if (w_upd && (r_ch == CW'(i))) begin
          r_sum[i] <= w_sum_next;
          r_out[i] <= w_out;
        end
        if (w_done) r_filt[i] <= r_out[i];
      end
    end
  end

  assign valid   = r_valid;
  assign busy    = (r_state != S_IDLE);
  assign overrun = r_overrun;

endmodule

// File: tb/tb_dc_blocker_mc.sv
// Self-checking bench for dc_blocker_mc (defaults: WIDTH=8, DEPTH=256, CHANNELS=2).
`timescale 1ns/1ps
module tb_dc_blocker_mc;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 256;
  localparam int CHANNELS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        audio_en;
  logic        overrun_clr;
  logic [15:0] sample;
  logic [15:0] filtered;
  logic        valid;
  logic        busy;
  logic        overrun;

  dc_blocker_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
    .clk        (clk),
    .reset      (reset),
    .audio_en   (audio_en),
    .sample     (sample),
    .filtered   (filtered),
    .valid      (valid),
    .busy       (busy),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int q0[$];
  int q1[$];
  int last_e0 = 0;
  int last_e1 = 0;

  typedef struct {
    int s0;
    int s1;
    int e0;
    int e1;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int out0();
    return int'($signed(filtered[7:0]));
  endfunction

  function automatic int out1();
    return int'($signed(filtered[15:8]));
  endfunction

  // Reference: window of the last DEPTH samples, mean floored, difference reduced to WIDTH bits.
  function automatic int fdiv(input int s);
    int d;
    d = s / DEPTH;
    if (s < 0 && d * DEPTH != s) d = d - 1;
    return d;
  endfunction

  function automatic int reduce(input int v);
    int w;
`ifdef DC_BLOCKER_MC_SAT_EN
    w = v;
    if (w > 127) w = 127;
    if (w < -128) w = -128;
`else
    w = v & 255;
    if (w >= 128) w = w - 256;
`endif
    return w;
  endfunction

  task automatic model_reset;
    q0.delete();
    q1.delete();
    repeat (DEPTH) begin
      q0.push_back(0);
      q1.push_back(0);
    end
  endtask

  task automatic model_push(input int s0, input int s1, output int e0, output int e1);
    int sum0 = 0;
    int sum1 = 0;
    q0.push_back(s0);
    void'(q0.pop_front());
    q1.push_back(s1);
    void'(q1.pop_front());
    foreach (q0[i]) sum0 += q0[i];
    foreach (q1[i]) sum1 += q1[i];
    e0 = reduce(s0 - fdiv(sum0));
    e1 = reduce(s1 - fdiv(sum1));
  endtask

  // One accepted sample; optionally a second strobe (dropped) at cycle drop_at after capture.
  task automatic strobe(input int s0, input int s1, input int drop_at, input bit clr_drop,
                        output int g0, output int g1);
    int e0;
    int e1;
    int lat;
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = s0[7:0];
    b1 = s1[7:0];
    model_push(s0, s1, e0, e1);
    sample   = {b1, b0};
    audio_en = 1'b1;
    tick;
    audio_en = 1'b0;
    sample   = 16'($urandom);
    lat = 1;
    while (!valid && lat < 20) begin
      if (lat == drop_at) begin
        audio_en    = 1'b1;
        overrun_clr = clr_drop;
      end
      tick;
      audio_en    = 1'b0;
      overrun_clr = 1'b0;
      lat++;
    end
    check("latency", lat, 6);
    g0 = out0();
    g1 = out1();
    check("model_ch0", g0, e0);
    check("model_ch1", g1, e1);
    last_e0 = e0;
    last_e1 = e1;
    tick;
    check("valid_one_cycle", int'(valid), 0);
    check("busy_after_valid", int'(busy), 0);
    tick;
  endtask

  task automatic do_reset(output int busy_cnt, output int vcount);
    reset       = 1'b1;
    audio_en    = 1'b0;
    overrun_clr = 1'b0;
    vcount      = 0;
    repeat (3) begin
      tick;
      if (valid) vcount++;
    end
    reset    = 1'b0;
    busy_cnt = 0;
    while (busy && busy_cnt < 3000) begin
      if (busy_cnt == 100) audio_en = 1'b1;
      tick;
      audio_en = 1'b0;
      busy_cnt++;
      if (valid) vcount++;
    end
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bc;
    int vc;
    int g0;
    int g1;
    int r0;
    int r1;
    int d;
    int exp_sat;

    reset       = 1'b1;
    audio_en    = 1'b0;
    overrun_clr = 1'b0;
    sample      = '0;

    // Constant +64: out = 64 - floor(64k/256) for the k-th sample.
    tbl[0] = '{64, 64, 64, 64};
    tbl[1] = '{64, 64, 64, 64};
    tbl[2] = '{64, 64, 64, 64};
    tbl[3] = '{64, 64, 63, 63};
    tbl[4] = '{64, 64, 63, 63};
    tbl[5] = '{64, 64, 63, 63};
    tbl[6] = '{64, 64, 63, 63};
    tbl[7] = '{64, 64, 62, 62};

    do_reset(bc, vc);
    check("reset_busy_cycles", bc, 512);
    check("reset_valid_pulses", vc, 0);
    check("reset_filtered", int'(filtered), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_valid", int'(valid), 0);

    for (int i = 0; i < 8; i++) begin
      strobe(tbl[i].s0, tbl[i].s1, 0, 1'b0, g0, g1);
      check("tbl_ch0", g0, tbl[i].e0);
      check("tbl_ch1", g1, tbl[i].e1);
    end
    for (int k = 9; k <= 310; k++) begin
      strobe(64, 64, 0, 1'b0, g0, g1);
      if (k == 256) check("dc64_k256", g0, 0);
    end
    check("dc64_wrap_ch0", g0, 0);
    check("dc64_wrap_ch1", g1, 0);

    do_reset(bc, vc);
    check("reset2_busy_cycles", bc, 512);
    for (int k = 0; k < 300; k++) strobe(20, -20, 0, 1'b0, g0, g1);
    check("pm20_ch0", g0, 0);
    check("pm20_ch1", g1, 0);
    strobe(30, -20, 0, 1'b0, g0, g1);
    check("step30_ch0", g0, 10);
    check("step30_ch1", g1, 0);

    // Overrun: dropped strobe, clear alone, clear colliding with a new drop.
    strobe(5, -5, 3, 1'b0, g0, g1);
    check("overrun_set", int'(overrun), 1);
    repeat (3) tick;
    check("hold_ch0", out0(), last_e0);
    check("hold_ch1", out1(), last_e1);
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
    check("overrun_clr", int'(overrun), 0);
    strobe(7, 7, 3, 1'b1, g0, g1);
    check("overrun_set_wins", int'(overrun), 1);
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
    strobe(8, 8, 5, 1'b0, g0, g1);
    check("overrun_in_done", int'(overrun), 1);
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;

    for (int k = 0; k < 40; k++) begin
      r0 = int'($urandom_range(0, 255)) - 128;
      r1 = int'($urandom_range(0, 255)) - 128;
      d  = int'($urandom_range(0, 5));
      strobe(r0, r1, d, 1'b0, g0, g1);
      check("rand_overrun", int'(overrun), (d != 0) ? 1 : 0);
      overrun_clr = 1'b1;
      tick;
      overrun_clr = 1'b0;
    end

    // Full-scale step after settling on -128.
    do_reset(bc, vc);
    check("reset3_busy_cycles", bc, 512);
    for (int k = 0; k < 256; k++) strobe(-128, -128, 0, 1'b0, g0, g1);
`ifdef DC_BLOCKER_MC_SAT_EN
    exp_sat = 127;
`else
    exp_sat = -1;
`endif
    strobe(127, -128, 0, 1'b0, g0, g1);
    check("fullscale_ch0", g0, exp_sat);
    check("fullscale_ch1", g1, 0);

    // Reset in the UPD cycle of ch1.
    sample   = {8'd60, 8'd50};
    audio_en = 1'b1;
    tick;
    audio_en = 1'b0;
    repeat (3) tick;
    check("busy_mid_sample", int'(busy), 1);
    do_reset(bc, vc);
    check("abort_valid_pulses", vc, 0);
    check("abort_busy_cycles", bc, 512);
    check("abort_filtered", int'(filtered), 0);
    check("abort_overrun", int'(overrun), 0);
    for (int k = 0; k < 30; k++) begin
      r0 = int'($urandom_range(0, 255)) - 128;
      r1 = int'($urandom_range(0, 255)) - 128;
      strobe(r0, r1, 0, 1'b0, g0, g1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dc_blocker_mc.md
DC_BLOCKER_MC -- requirements
Module: dc_blocker_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the signed sample width per channel.
REQ-002 SHALL have parameter DEPTH, default 256, giving the moving-average window length; it must be a power of two, 2..4096.
REQ-003 SHALL have parameter CHANNELS, default 2, giving the number of independent channels, 1..8.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port audio_en, input, 1 bit: sample strobe, one clk wide.
REQ-007 SHALL have port sample, input, CHANNELS*WIDTH bits: signed samples, channel n at bits [n*WIDTH +: WIDTH].
REQ-008 SHALL have port filtered, output, CHANNELS*WIDTH bits: signed DC-removed samples, same packing as sample.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse when filtered updates.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, set when audio_en is dropped.
REQ-012 SHALL have port overrun_clr, input, 1 bit: clears overrun.

Function
REQ-013 SHALL keep history in one RAM of CHANNELS*DEPTH words of WIDTH bits, address {ch, idx}, with 1-cycle registered read; the RAM is not reset and is cleared by the CLEAR state.
REQ-014 SHALL keep one signed running sum per channel of WIDTH+log2(DEPTH) bits, plus one shared write index idx of log2(DEPTH) bits.
REQ-015 SHALL implement FSM states CLEAR, IDLE, RD, UPD and DONE.
REQ-016 CLEAR: writes zero to each RAM address, one address per cycle, for CHANNELS*DEPTH cycles, then goes to IDLE; audio_en is ignored and overrun is not set.
REQ-017 IDLE: audio_en=1 captures all channels of sample into an input register, sets ch=0 and goes to RD.
REQ-018 RD: issues a RAM read at {ch, idx} and goes to UPD.
REQ-019 UPD computes s' = sum[ch] - old + new, where old is the RAM read data and new is the captured sample.
REQ-020 UPD writes sum[ch] <= s' and writes new into RAM at {ch, idx}.
REQ-021 UPD computes dc = s' >>> log2(DEPTH) (arithmetic shift, floor) and out[ch] = new - dc at WIDTH+1 bits, reduced to WIDTH bits per REQ-031.
REQ-022 From UPD, SHALL go to DONE if ch==CHANNELS-1; otherwise ch increments and the FSM goes to RD.
REQ-023 DONE: loads filtered from the out registers, pulses valid for one cycle, sets idx <= (idx+1) mod DEPTH and goes to IDLE.
REQ-024 Latency: valid SHALL be high exactly 2*CHANNELS+2 cycles after the cycle in which audio_en is sampled in IDLE (CHANNELS=2: 6 cycles); busy is low again in the cycle after valid.
REQ-025 SHALL hold filtered stable between valid pulses.
REQ-026 audio_en=1 in any state other than IDLE or CLEAR SHALL drop that sample and set overrun.
REQ-027 If overrun_clr and a new overrun occur in the same cycle, overrun SHALL be set (set wins).
REQ-028 The idx wrap at DEPTH-1 -> 0 SHALL evict the oldest sample correctly; sum SHALL never overflow its width.

Reset
REQ-029 reset=1 SHALL abort any state, including mid-channel, and on release SHALL enter CLEAR with its clear counter at 0.
REQ-030 reset SHALL set sums=0, idx=0, ch=0, filtered=0, valid=0, overrun=0; busy is 1 from the first cycle after reset until CLEAR completes.

Configuration
REQ-031 Macro DC_BLOCKER_MC_SAT_EN: when defined, out[ch] SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; when undefined, out[ch] SHALL be the two's-complement wrap of its low WIDTH bits.

Verification
REQ-032 After reset, count busy cycles with defaults -> busy high for exactly 512 cycles, filtered=0, overrun=0.
REQ-033 With defaults, apply a constant +64 on both channels, strobing every 10 cycles -> first output 64, then 64 - floor(64k/256) for the k-th sample; converges to 0 after 256 samples and stays 0 through idx wrap.
REQ-034 Drive ch0 at +20 and ch1 at -20 for 300 strobes -> both outputs 0 and no cross-talk; then a ch0 step to +30 -> ch0 output 10, ch1 output 0.
REQ-035 Issue audio_en 3 cycles after a prior strobe -> sample dropped, overrun=1; overrun_clr asserted alone -> overrun=0; overrun_clr together with a new drop -> overrun stays 1.
REQ-036 With WIDTH=8, settle on a DC of -128, then input +127 -> output 127 with DC_BLOCKER_MC_SAT_EN defined and -1 without it.
REQ-037 Assert reset during UPD of ch1 -> valid never pulses for that sample, CLEAR reruns, and subsequent outputs match a freshly reset model.
